// File: rtl/frac_div_sched.sv
// frac_div_sched: N/N+1 period scheduler for a fractional clock divider; config checking enabled by FRAC_DIV_CFG_CHECK_EN
module frac_div_sched #(
  parameter int CNT_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_num,
  input  logic [FRAC_W-1:0] cfg_den,
  output logic              clk_out,
  output logic              period_start,
  output logic              long_period,
  output logic              cfg_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic loaded, pend;
  logic [CNT_W-1:0] n, sh_n, cnt, p, n_e, p_n;
  logic [FRAC_W-1:0] a, b, sh_a, sh_b, a_e, b_e;
  logic [FRAC_W:0] acc, acc_e, s, acc_n;
  logic xfer, legal, use_sh, use_in, lng, boundary, start;
  assign cfg_ready = !rst && !pend;
  assign xfer = cfg_valid && cfg_ready;
`ifdef FRAC_DIV_CFG_CHECK_EN
  assign legal = (cfg_int >= CNT_W'(2)) && (cfg_int != '1) && (cfg_den != '0) && (cfg_num < cfg_den);
`else
  assign legal = 1'b1;
`endif
  assign boundary = state == RUN && cnt == p - CNT_W'(1);
  assign start = state == IDLE ? en && loaded : boundary && en;
  // Config and accumulator that feed the next period; a freshly applied config restarts from acc=0
  always_comb begin
    use_sh = state == RUN && pend;
    use_in = state == IDLE && xfer && legal;
    n_e = use_sh ? sh_n : use_in ? cfg_int : n;
    a_e = use_sh ? sh_a : use_in ? cfg_num : a;
    b_e = use_sh ? sh_b : use_in ? cfg_den : b;
    acc_e = (use_sh || use_in) ? '0 : acc;
    s = acc_e + {1'b0, a_e};
    lng = s >= {1'b0, b_e};
    acc_n = lng ? s - {1'b0, b_e} : s;
    p_n = n_e + {{(CNT_W-1){1'b0}}, lng};
  end
  // Config handshake, boundary-aligned config swap, period counter and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
      loaded <= 1'b0;
      pend <= 1'b0;
      acc <= '0;
      cnt <= '0;
      p <= '0;
      n <= '0;
      a <= '0;
      b <= '0;
      sh_n <= '0;
      sh_a <= '0;
      sh_b <= '0;
      clk_out <= 1'b0;
      period_start <= 1'b0;
      long_period <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (xfer) cfg_err <= !legal;
      if (use_in) begin
        n <= cfg_int;
        a <= cfg_num;
        b <= cfg_den;
        loaded <= 1'b1;
        acc <= '0;
      end
      if (xfer && legal && state == RUN) begin
        sh_n <= cfg_int;
        sh_a <= cfg_num;
        sh_b <= cfg_den;
        pend <= 1'b1;
      end
      if (use_sh && boundary) begin
        n <= sh_n;
        a <= sh_a;
        b <= sh_b;
        pend <= 1'b0;
        acc <= '0;
      end
      if (start) begin
        state <= RUN;
        cnt <= '0;
        p <= p_n;
        acc <= acc_n;
        period_start <= 1'b1;
        long_period <= lng;
        clk_out <= 1'b1;
      end else if (boundary) begin
        state <= IDLE;
        cnt <= '0;
        period_start <= 1'b0;
        long_period <= 1'b0;
        clk_out <= 1'b0;
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
        period_start <= 1'b0;
        clk_out <= (cnt + CNT_W'(1)) < (p >> 1);
      end else begin
        period_start <= 1'b0;
        clk_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_frac_div_sched.sv
// tb_frac_div_sched: randomized self-checking bench for frac_div_sched against a closed-form period model
module tb_frac_div_sched;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic cfg_valid = 1'b0;
  logic [7:0] cfg_int = '0;
  logic [7:0] cfg_num = '0;
  logic [7:0] cfg_den = 8'd1;
  logic cfg_ready, clk_out, period_start, long_period, cfg_err;
  int vectors = 0;
  int miscompares = 0;
  int cur_n, cur_a, cur_b, k, tot;
  int nx_n, nx_a, nx_b;

  frac_div_sched #(.CNT_W(8), .FRAC_W(8)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_int(cfg_int), .cfg_num(cfg_num), .cfg_den(cfg_den), .clk_out(clk_out),
    .period_start(period_start), .long_period(long_period), .cfg_err(cfg_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Period kk after a config is applied is long exactly when floor(kk*A/B) steps up
  function automatic int lk(input int kk);
    return ((kk + 1) * cur_a) / cur_b - (kk * cur_a) / cur_b;
  endfunction

  task automatic cfg_idle(input int nn, input int aa, input int bb);
    cfg_int = 8'(nn);
    cfg_num = 8'(aa);
    cfg_den = 8'(bb);
    cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
    chk("ready_idle", cfg_ready, 1);
    cur_n = nn;
    cur_a = aa;
    cur_b = bb;
    k = 0;
  endtask

  // mode 0: plain period, 1: offer nx_* config mid-period, 2: drop en mid-period
  task automatic run_period(input int mode);
    int el, elen, len, hi, lbad;
    el = lk(k);
    elen = cur_n + el;
    chk("period_start", period_start, 1);
    chk("long_period", long_period, el);
    len = 0;
    hi = 0;
    lbad = 0;
    do begin
      hi += int'(clk_out);
      if (long_period !== el[0]) lbad++;
      len++;
      if (len == 2 && mode == 1) begin
        cfg_int = 8'(nx_n);
        cfg_num = 8'(nx_a);
        cfg_den = 8'(nx_b);
        cfg_valid = 1'b1;
      end
      if (len == 2 && mode == 2) en = 1'b0;
      tick;
      if (cfg_valid) begin
        chk("ready_drop", cfg_ready, 0);
        cfg_valid = 1'b0;
      end
    end while (len < elen && period_start !== 1'b1);
    chk("period_len", len, elen);
    chk("high_cycles", hi, elen / 2);
    chk("long_stable", lbad, 0);
    tot += elen;
    k++;
    if (mode == 1) begin
      cur_n = nx_n;
      cur_a = nx_a;
      cur_b = nx_b;
      k = 0;
      chk("ready_back", cfg_ready, 1);
    end
    if (mode == 2) begin
      chk("idle_ps", period_start, 0);
      chk("idle_clk", clk_out, 0);
    end
  endtask

  initial begin
    int bad;
    tick;
    tick;
    chk("rst_clk", clk_out, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_long", long_period, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_ready", cfg_ready, 0);
    rst = 1'b0;
    tick;
    chk("ready_after_rst", cfg_ready, 1);
    chk("ps_after_rst", period_start, 0);
    cfg_idle(8, 7, 10);
`ifdef FRAC_DIV_CFG_CHECK_EN
    cfg_int = 8'd8;
    cfg_num = 8'd10;
    cfg_den = 8'd10;
    cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
    chk("err_set", cfg_err, 1);
    chk("err_ready", cfg_ready, 1);
`endif
    en = 1'b1;
    tick;
    chk("start_ps", period_start, 1);
    chk("start_clk", clk_out, 1);
    tot = 0;
    repeat (10) run_period(0);
    chk("cycles_10_periods", tot, 87);
    repeat (10) run_period(0);
    nx_n = 4; nx_a = 1; nx_b = 2;
    run_period(1);
`ifdef FRAC_DIV_CFG_CHECK_EN
    chk("err_clear", cfg_err, 0);
`endif
    repeat (6) run_period(0);
    nx_n = 5; nx_a = 0; nx_b = 1;
    run_period(1);
    repeat (4) run_period(0);
    for (int r = 0; r < 5; r++) begin
      nx_n = int'($urandom_range(3, 20));
      nx_b = int'($urandom_range(1, 15));
      nx_a = int'($urandom_range(0, nx_b - 1));
      run_period(1);
      repeat (8) run_period(0);
    end
    run_period(2);
    bad = 0;
    repeat (8) begin
      tick;
      bad += int'(period_start) + int'(clk_out);
    end
    chk("idle_quiet", bad, 0);
    en = 1'b1;
    tick;
    chk("restart_clk", clk_out, 1);
    repeat (5) run_period(0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("mid_rst_clk", clk_out, 0);
    chk("mid_rst_ps", period_start, 0);
    chk("mid_rst_long", long_period, 0);
    chk("mid_rst_err", cfg_err, 0);
    chk("mid_rst_ready", cfg_ready, 0);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      tick;
      bad += int'(period_start) + int'(clk_out);
    end
    chk("unloaded_quiet", bad, 0);
    en = 1'b0;
    cfg_idle(3, 1, 3);
    en = 1'b1;
    tick;
    chk("reload_clk", clk_out, 1);
    repeat (6) run_period(0);
`ifndef FRAC_DIV_CFG_CHECK_EN
    chk("err_tied", cfg_err, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/frac_div_sched.md
# frac_div_sched

Runtime-configurable dual-modulus scheduler for the fractional clock divider. It produces an output clock whose average period is N + A/B input cycles by mixing N-cycle and (N+1)-cycle periods under first-order accumulator control. For example, N=8, A=7, B=10 gives 87 cycles per 10 output periods. It replaces fixed-ratio N/N+1 switch points with a config handshake applied glitch-free at period boundaries, and adds per-period status for downstream logic.

## Interface
- CNT_W, 8: width of integer divisor N and the period counter
- FRAC_W, 8: width of fractional numerator A and denominator B
- clk_in  in  1  input clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable
- cfg_valid  in  1  config offered
- cfg_ready  out  1  config can be accepted
- cfg_int  in  CNT_W  integer divisor N; legal range 2..2^CNT_W-2
- cfg_num  in  FRAC_W  numerator A; legal when A < B
- cfg_den  in  FRAC_W  denominator B; legal when B >= 1
- clk_out  out  1  divided clock, registered
- period_start  out  1  one-cycle pulse on the first cycle of each output period
- long_period  out  1  current period is N+1 cycles; valid for the whole period
- cfg_err  out  1  sticky illegal-config flag

## Operation
- Registers:
  - active config N, A, B, plus a loaded flag
  - one-entry shadow config, plus a pend flag
  - accumulator acc, FRAC_W+1 bits
  - period counter cnt, CNT_W bits
  - period length P
- States:
  - IDLE: clk_out=0. Moves to RUN when en=1 and loaded=1.
  - RUN: periods run back to back. A boundary is the edge where cnt==P-1, and cnt wraps to 0 on that edge.
- At each period start, compute s = acc + A.
  - If s >= B: P = N+1, long_period=1, acc = s - B.
  - Otherwise: P = N, long_period=0, acc = s.
  - acc is always < B. The sum is computed at FRAC_W+1 bits, so there is no overflow.
- clk_out is 1 for cnt < P>>1 and 0 otherwise. Example: P=9 gives 4 high, 5 low.
- Handshake: a transfer occurs when cfg_valid && cfg_ready, and cfg_ready = !rst && !pend.
  - In IDLE, an accepted config is written to the active registers: loaded=1, acc=0.
  - In RUN, an accepted config is written to the shadow and pend=1. At the next boundary it is copied to active, acc is cleared to 0, and pend=0.
  - A config accepted on a boundary edge itself goes to the shadow and is applied at the following boundary.
- en=0 during RUN: the current period completes, then the block enters IDLE at the boundary. If pend is set, the shadow is applied at that boundary. en=1 again re-enters RUN with acc preserved.
- Reset mid-operation: on the next edge every register returns to its reset value. Any partial period is abandoned.

## Timing
- Reset values:
  - clk_out=0, period_start=0, long_period=0, cfg_err=0
  - cfg_ready=0 while rst=1, and 1 on the first cycle after rst=0
  - state=IDLE, loaded=0, pend=0, acc=0, cnt=0
- Start latency: the edge that samples en=1 with loaded=1 in IDLE makes the next cycle show period_start=1 and clk_out=1. This is one cycle of latency.
- period_start goes high in the same cycle that cnt==0, and long_period updates in that same cycle.
- The first period after a config is applied uses acc=0.
- All outputs are flops, except that cfg_ready is combinational from rst and pend.

## Configuration
- FRAC_DIV_CFG_CHECK_EN defined:
  - A config with N<2, N=2^CNT_W-1, B=0, or A>=B is still handshaken (consumed) but discarded.
  - cfg_err is set and stays set until reset or the next legal accepted config, which clears it.
- Not defined:
  - No checking is performed and cfg_err is tied to 0.
  - Output behaviour for an illegal config is unspecified.

## Test plan
- Config N=8, A=7, B=10, then en=1 → the long_period pattern over 10 periods is S L L S L L S L L L. That is 87 cycles between the 1st and 11th period_start, and the pattern repeats.
- Config N=5, A=0, B=1 → every period is 5 cycles with clk_out 2 high, 3 low, and long_period stays 0.
- Running at 8.7, offer N=4, A=1, B=2 mid-period → cfg_ready drops. The current period ends unchanged, the next period is 4 cycles with acc=0, and cfg_ready returns to 1.
- Running, drop en mid-period → the period completes, clk_out stays 0, and there are no further period_start pulses. Raise en → period_start appears one cycle later.
- With FRAC_DIV_CFG_CHECK_EN, offer A=10, B=10 → cfg_err=1 and the active config is unchanged. A following legal config clears cfg_err.
- Assert rst for 1 cycle mid-period → the next cycle shows all outputs at their reset values. No output starts until a new config and en.
